// File: rtl/model_matrix_pkg.sv
// model_matrix_pkg: shared FSM encoding, constants and address-width helper for the matrix stream blocks
package model_matrix_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DONE = 2'd2} state_t;
    localparam int DATA_W = 64;
    localparam int CONTROL_W = 64;
    localparam logic [DATA_W-1:0] ZERO_DATA = '0;
    localparam logic [DATA_W-1:0] ONE_DATA = DATA_W'(1);
    localparam logic [CONTROL_W-1:0] ZERO_CONTROL = '0;
    localparam logic [CONTROL_W-1:0] ONE_CONTROL = CONTROL_W'(1);
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/model_matrix_buffer_ram.sv
// model_matrix_buffer_ram: SIZE_I*SIZE_J word buffer, one write port and one combinational read port
module model_matrix_buffer_ram #(
    parameter int DATA_SIZE = 64,
    parameter int DEPTH = 16,
    parameter int AW = 4
) (
    input  logic                 CLK,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output logic [DATA_SIZE-1:0] rdata
);
    logic [DATA_SIZE-1:0] mem [DEPTH];
    always_ff @(posedge CLK) if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/model_matrix_stream_source.sv
// model_matrix_stream_source: host-loaded matrix buffer replayed row-major as an I/J-enabled element stream.
// Define MATRIX_STREAM_SOURCE_CHECK_EN to add the sticky SIZE_ERROR output.
module model_matrix_stream_source
    import model_matrix_pkg::*;
#(
    parameter int DATA_SIZE = 64,
    parameter int CONTROL_SIZE = 64,
    parameter int SIZE_I = 4,
    parameter int SIZE_J = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    output logic                 BUSY,
    input  logic                 LOAD_ENABLE,
    input  logic [DATA_SIZE-1:0] LOAD_I,
    input  logic [DATA_SIZE-1:0] LOAD_J,
    input  logic [DATA_SIZE-1:0] LOAD_DATA,
    input  logic [DATA_SIZE-1:0] SIZE_I_IN,
    input  logic [DATA_SIZE-1:0] SIZE_J_IN,
    input  logic                 REQUEST,
`ifdef MATRIX_STREAM_SOURCE_CHECK_EN
    output logic                 SIZE_ERROR,
`endif
    output logic                 DATA_OUT_I_ENABLE,
    output logic                 DATA_OUT_J_ENABLE,
    output logic [DATA_SIZE-1:0] DATA_OUT
);
    localparam int DEPTH = SIZE_I * SIZE_J;
    localparam int AW = clog2(DEPTH);
    state_t state_q, state_d;
    logic [DATA_SIZE-1:0] i_q, i_d, j_q, j_d, size_i_q, size_i_d, size_j_q, size_j_d;
    logic [DATA_SIZE-1:0] data_out_q, data_out_d, rdata;
    logic ien_q, ien_d, jen_q, jen_d;
    logic start_ok, size_bad, load_ok, issue, last_j, drained;
`ifdef MATRIX_STREAM_SOURCE_CHECK_EN
    logic size_error_q, size_error_d;
`endif
    model_matrix_buffer_ram #(.DATA_SIZE(DATA_SIZE), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .CLK  (CLK),
        .we   (load_ok),
        .waddr(AW'(LOAD_I * DATA_SIZE'(SIZE_J) + LOAD_J)),
        .wdata(LOAD_DATA),
        .raddr(AW'(i_q * DATA_SIZE'(SIZE_J) + j_q)),
        .rdata(rdata)
    );
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            i_q        <= ZERO_DATA;
            j_q        <= ZERO_DATA;
            size_i_q   <= ZERO_DATA;
            size_j_q   <= ZERO_DATA;
            data_out_q <= ZERO_DATA;
            ien_q      <= 1'b0;
            jen_q      <= 1'b0;
`ifdef MATRIX_STREAM_SOURCE_CHECK_EN
            size_error_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            size_i_q   <= size_i_d;
            size_j_q   <= size_j_d;
            data_out_q <= data_out_d;
            ien_q      <= ien_d;
            jen_q      <= jen_d;
`ifdef MATRIX_STREAM_SOURCE_CHECK_EN
            size_error_q <= size_error_d;
`endif
        end
    end
    // i reaching size_i_int marks every element issued; STREAM lingers one cycle so READY trails the last pulse
    always_comb begin
        size_bad   = SIZE_I_IN == ZERO_DATA || SIZE_J_IN == ZERO_DATA ||
                     SIZE_I_IN > DATA_SIZE'(SIZE_I) || SIZE_J_IN > DATA_SIZE'(SIZE_J);
        start_ok   = state_q == IDLE && START;
        drained    = i_q == size_i_q;
        issue      = state_q == STREAM && REQUEST && !drained;
        last_j     = j_q == size_j_q - ONE_DATA;
        load_ok    = LOAD_ENABLE && !BUSY && LOAD_I < DATA_SIZE'(SIZE_I) && LOAD_J < DATA_SIZE'(SIZE_J);
        state_d    = start_ok ? (size_bad ? DONE : STREAM) :
                     (state_q == STREAM && drained) ? DONE :
                     state_q == DONE ? IDLE : state_q;
        size_i_d   = start_ok ? SIZE_I_IN : size_i_q;
        size_j_d   = start_ok ? SIZE_J_IN : size_j_q;
        i_d        = start_ok ? ZERO_DATA : (issue && last_j) ? i_q + ONE_DATA : i_q;
        j_d        = start_ok ? ZERO_DATA : issue ? (last_j ? ZERO_DATA : j_q + ONE_DATA) : j_q;
        data_out_d = issue ? rdata : data_out_q;
        jen_d      = issue;
        ien_d      = issue && j_q == ZERO_DATA;
`ifdef MATRIX_STREAM_SOURCE_CHECK_EN
        size_error_d = ((start_ok && size_bad) || (LOAD_ENABLE && !load_ok)) ? 1'b1 :
                       start_ok ? 1'b0 : size_error_q;
`endif
    end
    always_comb begin
        BUSY              = state_q == STREAM;
        READY             = state_q == DONE;
        DATA_OUT          = data_out_q;
        DATA_OUT_I_ENABLE = ien_q;
        DATA_OUT_J_ENABLE = jen_q;
`ifdef MATRIX_STREAM_SOURCE_CHECK_EN
        SIZE_ERROR        = size_error_q;
`endif
    end
endmodule

// File: tb/tb_model_matrix_stream_source.sv
// tb_model_matrix_stream_source: random and directed streams checked against a row-major matrix reference model
module tb_model_matrix_stream_source;
    localparam int DS = 64;
    localparam int SI = 4;
    localparam int SJ = 4;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic START = 1'b0, LOAD_ENABLE = 1'b0, REQUEST = 1'b0;
    logic [DS-1:0] LOAD_I = '0, LOAD_J = '0, LOAD_DATA = '0, SIZE_I_IN = '0, SIZE_J_IN = '0;
    logic READY, BUSY, DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE;
    logic [DS-1:0] DATA_OUT;
`ifdef MATRIX_STREAM_SOURCE_CHECK_EN
    logic SIZE_ERROR;
`endif
    logic [DS-1:0] ref_mem [SI][SJ];
    logic [DS-1:0] last_m;
    logic err_m;
    int n_chk = 0, n_fail = 0;

    model_matrix_stream_source #(.DATA_SIZE(DS), .CONTROL_SIZE(64), .SIZE_I(SI), .SIZE_J(SJ)) dut (
        .CLK(CLK), .RST(RST), .START(START), .READY(READY), .BUSY(BUSY),
        .LOAD_ENABLE(LOAD_ENABLE), .LOAD_I(LOAD_I), .LOAD_J(LOAD_J), .LOAD_DATA(LOAD_DATA),
        .SIZE_I_IN(SIZE_I_IN), .SIZE_J_IN(SIZE_J_IN), .REQUEST(REQUEST),
`ifdef MATRIX_STREAM_SOURCE_CHECK_EN
        .SIZE_ERROR(SIZE_ERROR),
`endif
        .DATA_OUT_I_ENABLE(DATA_OUT_I_ENABLE), .DATA_OUT_J_ENABLE(DATA_OUT_J_ENABLE), .DATA_OUT(DATA_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_err(input string tag);
`ifdef MATRIX_STREAM_SOURCE_CHECK_EN
        chk(tag, SIZE_ERROR, err_m);
`endif
    endtask

    task automatic load(input int i, input int j, input logic [63:0] d);
        LOAD_I = i; LOAD_J = j; LOAD_DATA = d; LOAD_ENABLE = 1'b1;
        step();
        LOAD_ENABLE = 1'b0;
        if (i < SI && j < SJ) ref_mem[i][j] = d;
        else err_m = 1'b1;
        chk_err("size_err_load");
    endtask

    task automatic reject(input int si, input int sj);
        SIZE_I_IN = si; SIZE_J_IN = sj; START = 1'b1;
        step();
        START = 1'b0;
        err_m = 1'b1;
        chk("rej_ready", READY, 1);
        chk("rej_busy", BUSY, 0);
        chk("rej_jen", DATA_OUT_J_ENABLE, 0);
        chk_err("rej_size_err");
        step();
        chk("rej_ready_after", READY, 0);
    endtask

    // mode 0: REQUEST held high, 1: pattern 1,0,0 repeating, 2: random
    task automatic stream(input int si, input int sj, input int mode, input bit junk);
        int total, idx, cyc;
        logic req;
        total = si * sj; idx = 0; cyc = 0;
        SIZE_I_IN = si; SIZE_J_IN = sj; START = 1'b1;
        step();
        START = 1'b0;
        err_m = 1'b0;
        chk("busy_start", BUSY, 1);
        chk_err("size_err_start");
        while (idx < total && cyc < 400) begin
            req = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            cyc++;
            REQUEST = req;
            if (junk && $urandom_range(0, 3) == 0) begin
                START = 1'b1; LOAD_ENABLE = 1'b1; LOAD_I = '0; LOAD_J = '0; LOAD_DATA = '1;
                err_m = 1'b1;
            end
            step();
            START = 1'b0; LOAD_ENABLE = 1'b0; REQUEST = 1'b0;
            chk("ready_mid", READY, 0);
            chk("jen", DATA_OUT_J_ENABLE, req);
            if (req) begin
                chk("ien", DATA_OUT_I_ENABLE, idx % sj == 0);
                last_m = ref_mem[idx / sj][idx % sj];
                chk("data", DATA_OUT, last_m);
                idx++;
            end else begin
                chk("ien_idle", DATA_OUT_I_ENABLE, 0);
                chk("hold", DATA_OUT, last_m);
            end
            chk("busy", BUSY, 1);
            chk_err("size_err_mid");
        end
        if (idx < total) chk("stream_timeout", idx, total);
        REQUEST = 1'($urandom_range(0, 1));
        step();
        REQUEST = 1'b0;
        chk("ready", READY, 1);
        chk("busy_done", BUSY, 0);
        chk("jen_done", DATA_OUT_J_ENABLE, 0);
        chk("hold_done", DATA_OUT, last_m);
        START = 1'b1;
        step();
        START = 1'b0;
        chk("start_in_ready", BUSY, 0);
        chk("ready_once", READY, 0);
    endtask

    initial begin
        err_m = 1'b0;
        last_m = '0;
        #1 RST = 1'b1;
        #1;
        chk("rst_ready", READY, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_jen", DATA_OUT_J_ENABLE, 0);
        chk("rst_ien", DATA_OUT_I_ENABLE, 0);
        chk("rst_data", DATA_OUT, 0);
        chk_err("rst_size_err");
        repeat (2) step();
        RST = 1'b0;
        step();
        for (int i = 0; i < SI; i++)
            for (int j = 0; j < SJ; j++) load(i, j, 64'(10 * i + j));
        stream(2, 3, 0, 1'b0);
        stream(2, 3, 1, 1'b0);
        reject(0, 3);
        reject(3, 5);
        reject(5, 2);
        reject(2, 0);
        load(4, 0, 64'hdead);
        load(0, 4, 64'hbeef);
        stream(4, 4, 2, 1'b0);
        // reset after the third element of a 2x3 stream
        SIZE_I_IN = 2; SIZE_J_IN = 3; START = 1'b1;
        step();
        START = 1'b0;
        REQUEST = 1'b1;
        repeat (3) step();
        REQUEST = 1'b0;
        chk("pre_rst_data", DATA_OUT, 2);
        #2 RST = 1'b1;
        #1;
        chk("arst_jen", DATA_OUT_J_ENABLE, 0);
        chk("arst_ien", DATA_OUT_I_ENABLE, 0);
        chk("arst_data", DATA_OUT, 0);
        chk("arst_busy", BUSY, 0);
        chk("arst_ready", READY, 0);
        last_m = '0;
        err_m = 1'b0;
        repeat (2) step();
        RST = 1'b0;
        step();
        chk("post_rst_ready", READY, 0);
        chk("post_rst_busy", BUSY, 0);
        stream(2, 3, 0, 1'b0);
        stream(2, 3, 2, 1'b1);
        for (int t = 0; t < 25; t++) begin
            repeat ($urandom_range(0, 3)) load($urandom_range(0, 5), $urandom_range(0, 5), {$urandom, $urandom});
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 3))
                    0: reject(0, $urandom_range(1, 4));
                    1: reject($urandom_range(1, 4), 0);
                    2: reject($urandom_range(5, 9), $urandom_range(1, 4));
                    default: reject($urandom_range(1, 4), $urandom_range(5, 9));
                endcase
            end else begin
                stream($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
